// File: rtl/branch_ctrl.sv
// branch_ctrl
// Branch prediction controller sitting between fetch and execute.
// Conditional branches seen at fetch get a registered taken/target prediction
// from one of four policies: never-taken, backward-taken, forward-taken, or a
// table of 2-bit saturating counters. Branches resolved in execute train the
// table and are checked against the direction that was predicted for them. A
// mispredict produces a one-cycle redirect and a fixed-length flush.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   mode[1:0]             00 never, 01 backward, 10 forward, 11 counter table
//   f_valid/f_pc/f_inst   fetch-side instruction to predict
//   p_valid/p_taken/p_target
//                         registered prediction, one cycle after fetch
//   r_valid/r_pc/r_taken/r_target/r_pred_taken
//                         resolved branch from execute
//   redirect_valid/redirect_pc
//                         one-cycle pulse carrying the corrected PC
//   flush                 squash younger stages, FLUSH_CYCLES per mispredict
//   stat_branches/stat_mispredicts
//                         saturating event counters
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | normal operation, resolves and fetches are accepted
// S_FLUSH | flush asserted, resolves and fetches are ignored; cnt_q
//         | counts down the remaining flush cycles to terminal count 0

module branch_ctrl #(
  parameter int WORD_WIDTH   = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  f_valid,
  input  logic [WORD_WIDTH-1:0] f_pc,
  input  logic [WORD_WIDTH-1:0] f_inst,
  output logic                  p_valid,
  output logic                  p_taken,
  output logic [WORD_WIDTH-1:0] p_target,
  input  logic                  r_valid,
  input  logic [WORD_WIDTH-1:0] r_pc,
  input  logic                  r_taken,
  input  logic [WORD_WIDTH-1:0] r_target,
  input  logic                  r_pred_taken,
  output logic                  redirect_valid,
  output logic [WORD_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic [15:0]           stat_branches,
  output logic [15:0]           stat_mispredicts
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  p_valid_q, p_valid_d;
  logic                  p_taken_q, p_taken_d;
  logic [WORD_WIDTH-1:0] p_target_q, p_target_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [WORD_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [15:0]           stat_br_q, stat_br_d;
  logic [15:0]           stat_mp_q, stat_mp_d;
  logic [1:0]            bht_q [BHT_ENTRIES];
  logic [1:0]            bht_d [BHT_ENTRIES];

  logic                  is_branch;
  logic [12:0]           imm13;
  logic [WORD_WIDTH-1:0] imm;
  logic                  imm_neg;
  logic                  imm_pos;
  logic [IW-1:0]         f_idx;
  logic [IW-1:0]         r_idx;
  logic                  dir_taken;
  logic                  accept_f;
  logic                  accept_r;
  logic                  mispredict;
  logic                  unused_inst_bits;

  // funct3 and the register fields play no part in prediction
  assign unused_inst_bits = ^f_inst[24:12];

  // Fetch decode and direction selection
  always_comb begin
    is_branch = (f_inst[6:0] == OP_BRANCH);
    imm13     = {f_inst[31], f_inst[7], f_inst[30:25], f_inst[11:8], 1'b0};
    imm       = {{(WORD_WIDTH-13){imm13[12]}}, imm13};
    imm_neg   = imm13[12];
    imm_pos   = !imm13[12] && (imm13 != 13'd0);
    f_idx     = f_pc[IW+1:2];
    r_idx     = r_pc[IW+1:2];
    dir_taken = 1'b0;
    unique case (mode)
      2'b00:   dir_taken = 1'b0;
      2'b01:   dir_taken = imm_neg;
      2'b10:   dir_taken = imm_pos;
      default: dir_taken = bht_q[f_idx][1];
    endcase
  end

  assign accept_f   = (state_q == S_IDLE) && f_valid && is_branch;
  assign accept_r   = (state_q == S_IDLE) && r_valid;
  assign mispredict = accept_r && (r_taken != r_pred_taken);

  // Prediction registers: taken/target hold when nothing new is predicted
  always_comb begin
    p_valid_d  = accept_f;
    p_taken_d  = p_taken_q;
    p_target_d = p_target_q;
    if (accept_f) begin
      p_taken_d  = dir_taken;
      p_target_d = dir_taken ? (f_pc + imm) : (f_pc + WORD_WIDTH'(4));
    end
  end

  // Redirect / flush sequencing
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (mispredict) begin
          state_d          = S_FLUSH;
          cnt_d            = CNT_LOAD;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = r_taken ? r_target : (r_pc + WORD_WIDTH'(4));
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter table training; the fetch lookup above reads bht_q, so a
  // same-edge update and lookup at one index sees the old counter.
  always_comb begin
    for (int i = 0; i < BHT_ENTRIES; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (accept_r) begin
      if (r_taken) begin
        if (bht_q[r_idx] != 2'b11) bht_d[r_idx] = bht_q[r_idx] + 2'b01;
      end else begin
        if (bht_q[r_idx] != 2'b00) bht_d[r_idx] = bht_q[r_idx] - 2'b01;
      end
    end
  end

  // Saturating statistics
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (accept_r && (stat_br_q != 16'hFFFF)) stat_br_d = stat_br_q + 16'd1;
    if (mispredict && (stat_mp_q != 16'hFFFF)) stat_mp_d = stat_mp_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      p_valid_q        <= 1'b0;
      p_taken_q        <= 1'b0;
      p_target_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stat_br_q        <= '0;
      stat_mp_q        <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      p_valid_q        <= p_valid_d;
      p_taken_q        <= p_taken_d;
      p_target_q       <= p_target_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      stat_br_q        <= stat_br_d;
      stat_mp_q        <= stat_mp_d;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign p_valid          = p_valid_q;
  assign p_taken          = p_taken_q;
  assign p_target         = p_target_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = (state_q == S_FLUSH);
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        f_valid = 1'b0;
  logic [31:0] f_pc = '0;
  logic [31:0] f_inst = '0;
  logic        p_valid;
  logic        p_taken;
  logic [31:0] p_target;
  logic        r_valid = 1'b0;
  logic [31:0] r_pc = '0;
  logic        r_taken = 1'b0;
  logic [31:0] r_target = '0;
  logic        r_pred_taken = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;

  int tests_run = 0;
  int tests_failed = 0;

  branch_ctrl #(.WORD_WIDTH(32), .BHT_ENTRIES(64), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .f_valid(f_valid), .f_pc(f_pc), .f_inst(f_inst),
    .p_valid(p_valid), .p_taken(p_taken), .p_target(p_target),
    .r_valid(r_valid), .r_pc(r_pc), .r_taken(r_taken), .r_target(r_target),
    .r_pred_taken(r_pred_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc_b(input logic [31:0] imm);
    enc_b = {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    f_valid = 1'b0;
    r_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic predict(input logic [31:0] pc, input logic [31:0] inst);
    f_valid = 1'b1;
    f_pc    = pc;
    f_inst  = inst;
    tick();
    f_valid = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic pred,
                         input logic [31:0] tgt);
    r_valid      = 1'b1;
    r_pc         = pc;
    r_taken      = tk;
    r_pred_taken = pred;
    r_target     = tgt;
    tick();
    r_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tests_run++;
    if ({p_valid, p_taken, redirect_valid, flush} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {p_valid, p_taken, redirect_valid, flush});
    end
    tests_run++;
    if ({p_target, redirect_pc} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_pcs: got %h/%h expected 0/0", p_target, redirect_pc);
    end
    tests_run++;
    if ({stat_branches, stat_mispredicts} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_stats: got %h/%h expected 0/0", stat_branches, stat_mispredicts);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_static;
    do_reset();
    mode = 2'b01;
    predict(32'h100, enc_b(32'hFFFF_FFF8));
    tests_run++;
    if ({p_valid, p_taken, p_target} !== {2'b11, 32'h0000_00F8}) begin
      tests_failed++;
      $display("FAIL bwd_neg: got v=%b t=%b tgt=%h expected v=1 t=1 tgt=f8", p_valid, p_taken, p_target);
    end
    predict(32'h100, enc_b(32'd16));
    tests_run++;
    if ({p_valid, p_taken, p_target} !== {2'b10, 32'h0000_0104}) begin
      tests_failed++;
      $display("FAIL bwd_pos: got v=%b t=%b tgt=%h expected v=1 t=0 tgt=104", p_valid, p_taken, p_target);
    end
    mode = 2'b10;
    predict(32'h100, enc_b(32'd16));
    tests_run++;
    if ({p_valid, p_taken, p_target} !== {2'b11, 32'h0000_0110}) begin
      tests_failed++;
      $display("FAIL fwd_pos: got v=%b t=%b tgt=%h expected v=1 t=1 tgt=110", p_valid, p_taken, p_target);
    end
    predict(32'h100, enc_b(32'd0));
    tests_run++;
    if ({p_valid, p_taken, p_target} !== {2'b10, 32'h0000_0104}) begin
      tests_failed++;
      $display("FAIL fwd_zero: got v=%b t=%b tgt=%h expected v=1 t=0 tgt=104", p_valid, p_taken, p_target);
    end
    mode = 2'b01;
    predict(32'h100, enc_b(32'd0));
    tests_run++;
    if (p_taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL bwd_zero: got t=%b expected t=0", p_taken);
    end
    mode = 2'b10;
    predict(32'h100, enc_b(32'hFFFF_FFF8));
    tests_run++;
    if ({p_taken, p_target} !== {1'b0, 32'h0000_0104}) begin
      tests_failed++;
      $display("FAIL fwd_neg: got t=%b tgt=%h expected t=0 tgt=104", p_taken, p_target);
    end
    predict(32'h200, enc_b(32'd64));
    predict(32'h100, 32'h0000_0013);
    tests_run++;
    if ({p_valid, p_taken, p_target} !== {2'b01, 32'h0000_0240}) begin
      tests_failed++;
      $display("FAIL non_branch_hold: got v=%b t=%b tgt=%h expected v=0 t=1 tgt=240", p_valid, p_taken, p_target);
    end
    mode = 2'b00;
    predict(32'h100, enc_b(32'hFFFF_FFF8));
    tests_run++;
    if ({p_valid, p_taken, p_target} !== {2'b10, 32'h0000_0104}) begin
      tests_failed++;
      $display("FAIL never_taken: got v=%b t=%b tgt=%h expected v=1 t=0 tgt=104", p_valid, p_taken, p_target);
    end
    tick();
    tests_run++;
    if (p_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_fetch: got v=%b expected v=0", p_valid);
    end
  endtask

  task automatic test_bht;
    do_reset();
    mode = 2'b11;
    predict(32'h200, enc_b(32'd32));
    tests_run++;
    if ({p_valid, p_taken, p_target} !== {2'b10, 32'h0000_0204}) begin
      tests_failed++;
      $display("FAIL bht_reset_nt: got v=%b t=%b tgt=%h expected v=1 t=0 tgt=204", p_valid, p_taken, p_target);
    end
    resolve(32'h200, 1'b1, 1'b1, 32'h220);
    resolve(32'h200, 1'b1, 1'b1, 32'h220);
    predict(32'h200, enc_b(32'd32));
    tests_run++;
    if ({p_taken, p_target} !== {1'b1, 32'h0000_0220}) begin
      tests_failed++;
      $display("FAIL bht_trained_t: got t=%b tgt=%h expected t=1 tgt=220", p_taken, p_target);
    end
    for (int i = 0; i < 3; i++) resolve(32'h200, 1'b0, 1'b0, 32'h220);
    predict(32'h200, enc_b(32'd32));
    tests_run++;
    if (p_taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL bht_trained_nt: got t=%b expected t=0", p_taken);
    end
    resolve(32'h200, 1'b0, 1'b0, 32'h220);
    resolve(32'h200, 1'b1, 1'b1, 32'h220);
    predict(32'h200, enc_b(32'd32));
    tests_run++;
    if (p_taken !== 1'b0) begin
      tests_failed++;
      $display("FAIL bht_sat_zero: got t=%b expected t=0", p_taken);
    end
    tests_run++;
    if ({stat_branches, stat_mispredicts, redirect_valid, flush} !== {16'd7, 16'd0, 2'b00}) begin
      tests_failed++;
      $display("FAIL bht_stats: got br=%0d mp=%0d rv=%b fl=%b expected br=7 mp=0 rv=0 fl=0",
               stat_branches, stat_mispredicts, redirect_valid, flush);
    end
  endtask

  task automatic test_mispredict;
    do_reset();
    mode = 2'b11;
    resolve(32'h300, 1'b0, 1'b1, 32'h999);
    tests_run++;
    if ({redirect_valid, flush, redirect_pc} !== {2'b11, 32'h0000_0304}) begin
      tests_failed++;
      $display("FAIL mp_redirect: got rv=%b fl=%b pc=%h expected rv=1 fl=1 pc=304", redirect_valid, flush, redirect_pc);
    end
    r_valid = 1'b1; r_pc = 32'h300; r_taken = 1'b1; r_pred_taken = 1'b0; r_target = 32'h80;
    f_valid = 1'b1; f_pc = 32'h100; f_inst = enc_b(32'hFFFF_FFF8);
    tick();
    tests_run++;
    if ({redirect_valid, flush, p_valid} !== 3'b010) begin
      tests_failed++;
      $display("FAIL mp_flush2: got rv=%b fl=%b pv=%b expected rv=0 fl=1 pv=0", redirect_valid, flush, p_valid);
    end
    tick();
    r_valid = 1'b0;
    f_valid = 1'b0;
    tests_run++;
    if ({flush, redirect_valid, redirect_pc} !== {2'b00, 32'h0000_0304}) begin
      tests_failed++;
      $display("FAIL mp_flush_end: got fl=%b rv=%b pc=%h expected fl=0 rv=0 pc=304", flush, redirect_valid, redirect_pc);
    end
    tests_run++;
    if ({stat_branches, stat_mispredicts} !== {16'd1, 16'd1}) begin
      tests_failed++;
      $display("FAIL mp_ignored_stats: got br=%0d mp=%0d expected br=1 mp=1", stat_branches, stat_mispredicts);
    end
    resolve(32'h300, 1'b1, 1'b1, 32'h80);
    predict(32'h300, enc_b(32'd8));
    tests_run++;
    if ({p_valid, p_taken} !== 2'b10) begin
      tests_failed++;
      $display("FAIL mp_bht_unchanged: got v=%b t=%b expected v=1 t=0", p_valid, p_taken);
    end
  endtask

  task automatic test_taken_mispredict;
    do_reset();
    mode = 2'b11;
    resolve(32'h400, 1'b1, 1'b0, 32'h80);
    tests_run++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0000_0080}) begin
      tests_failed++;
      $display("FAIL tmp_redirect: got rv=%b pc=%h expected rv=1 pc=80", redirect_valid, redirect_pc);
    end
    tick();
    tick();
    r_valid = 1'b1; r_pc = 32'h400; r_taken = 1'b0; r_pred_taken = 1'b0;
    f_valid = 1'b1; f_pc = 32'h400; f_inst = enc_b(32'd16);
    tick();
    r_valid = 1'b0;
    f_valid = 1'b0;
    tests_run++;
    if ({p_valid, p_taken, p_target} !== {2'b11, 32'h0000_0410}) begin
      tests_failed++;
      $display("FAIL same_edge_old: got v=%b t=%b tgt=%h expected v=1 t=1 tgt=410", p_valid, p_taken, p_target);
    end
    predict(32'h400, enc_b(32'd16));
    tests_run++;
    if ({p_taken, p_target} !== {1'b0, 32'h0000_0404}) begin
      tests_failed++;
      $display("FAIL same_edge_new: got t=%b tgt=%h expected t=0 tgt=404", p_taken, p_target);
    end
    tests_run++;
    if ({stat_branches, stat_mispredicts, redirect_pc} !== {16'd2, 16'd1, 32'h0000_0080}) begin
      tests_failed++;
      $display("FAIL tmp_stats: got br=%0d mp=%0d pc=%h expected br=2 mp=1 pc=80",
               stat_branches, stat_mispredicts, redirect_pc);
    end
  endtask

  task automatic test_reset_mid_flush;
    do_reset();
    mode = 2'b11;
    resolve(32'h504, 1'b1, 1'b1, 32'h0);
    resolve(32'h504, 1'b1, 1'b1, 32'h0);
    resolve(32'h300, 1'b0, 1'b1, 32'h0);
    tests_run++;
    if ({flush, redirect_valid} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rmf_pre: got fl=%b rv=%b expected fl=1 rv=1", flush, redirect_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({flush, redirect_valid, redirect_pc} !== {2'b00, 32'h0}) begin
      tests_failed++;
      $display("FAIL rmf_async: got fl=%b rv=%b pc=%h expected fl=0 rv=0 pc=0", flush, redirect_valid, redirect_pc);
    end
    tests_run++;
    if ({stat_branches, stat_mispredicts} !== 32'h0) begin
      tests_failed++;
      $display("FAIL rmf_stats: got br=%0d mp=%0d expected 0/0", stat_branches, stat_mispredicts);
    end
    tick();
    rst_n = 1'b1;
    predict(32'h504, enc_b(32'd8));
    tests_run++;
    if ({p_valid, p_taken} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rmf_bht_nt: got v=%b t=%b expected v=1 t=0", p_valid, p_taken);
    end
    resolve(32'h504, 1'b1, 1'b1, 32'h0);
    predict(32'h504, enc_b(32'd8));
    tests_run++;
    if ({p_taken, p_target} !== {1'b1, 32'h0000_050C}) begin
      tests_failed++;
      $display("FAIL rmf_bht_weak: got t=%b tgt=%h expected t=1 tgt=50c", p_taken, p_target);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_bht();
    test_mispredict();
    test_taken_mispredict();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
